// File: rtl/lock_queue_arbiter.sv
// Lock arbiter: serialises lock/unlock commands from accelerators over an input stream and
// returns grant/reject acks, queueing contenders per lock and handing over round-robin.
module lock_queue_arbiter #(
    parameter int unsigned NUM_LOCKS       = 4,
    parameter logic [7:0]  CMD_LOCK_CODE   = 8'h04,
    parameter logic [7:0]  CMD_UNLOCK_CODE = 8'h05,
    parameter logic [7:0]  ACK_OK_CODE     = 8'h01,
    parameter logic [7:0]  ACK_REJECT_CODE = 8'h00
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [63:0] inStream_TDATA,
    input  logic        inStream_TVALID,
    input  logic [3:0]  inStream_TID,
    output logic        inStream_TREADY,
    output logic [7:0]  outStream_TDATA,
    output logic        outStream_TVALID,
    input  logic        outStream_TREADY,
    output logic [3:0]  outStream_TDEST
);

    localparam int unsigned IdW    = (NUM_LOCKS > 1) ? $clog2(NUM_LOCKS) : 1;
    localparam logic [IdW-1:0] IdMask = IdW'(NUM_LOCKS - 1);

    typedef enum logic [1:0] {StReadCmd, StDecode, StSendAck} state_e;

    state_e                       state_q, state_d;
    logic [7:0]                   cmd_q, cmd_d;
    logic [IdW-1:0]               id_q, id_d;
    logic [3:0]                   tid_q, tid_d;
    logic [NUM_LOCKS-1:0]         held_q, held_d;
    logic [NUM_LOCKS-1:0][3:0]    owner_q, owner_d;
    logic [NUM_LOCKS-1:0][15:0]   waiters_q, waiters_d;
    logic [7:0]                   ack_data_q, ack_data_d;
    logic [3:0]                   ack_dest_q, ack_dest_d;

    logic [3:0]  cur_owner;
    logic [15:0] cur_waiters;
    logic        grant_found;
    logic [3:0]  grant_tid;
    logic [3:0]  scan_idx;
    logic        unused_tdata;

    assign unused_tdata = ^{inStream_TDATA[63:16], inStream_TDATA[15:8+IdW]};

    assign cur_owner   = owner_q[id_q];
    assign cur_waiters = waiters_q[id_q];

    // Hand-over scan starts just after the releasing owner and wraps modulo 16.
    always_comb begin
        grant_found = 1'b0;
        grant_tid   = '0;
        scan_idx    = '0;
        for (int k = 1; k <= 16; k++) begin
            scan_idx = cur_owner + 4'(k);
            if (!grant_found && cur_waiters[scan_idx]) begin
                grant_found = 1'b1;
                grant_tid   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        id_d       = id_q;
        tid_d      = tid_q;
        held_d     = held_q;
        owner_d    = owner_q;
        waiters_d  = waiters_q;
        ack_data_d = ack_data_q;
        ack_dest_d = ack_dest_q;
        unique case (state_q)
            StReadCmd: begin
                if (inStream_TVALID) begin
                    cmd_d   = inStream_TDATA[7:0];
                    id_d    = inStream_TDATA[8 +: IdW] & IdMask;
                    tid_d   = inStream_TID;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = StReadCmd;
                if (cmd_q == CMD_LOCK_CODE) begin
                    if (!held_q[id_q]) begin
                        held_d[id_q]  = 1'b1;
                        owner_d[id_q] = tid_q;
                        ack_data_d    = ACK_OK_CODE;
                        ack_dest_d    = tid_q;
                        state_d       = StSendAck;
                    end else if (cur_owner == tid_q) begin
                        ack_data_d = ACK_REJECT_CODE;
                        ack_dest_d = tid_q;
                        state_d    = StSendAck;
                    end else begin
                        waiters_d[id_q][tid_q] = 1'b1;
                    end
                end else if (cmd_q == CMD_UNLOCK_CODE && held_q[id_q] && cur_owner == tid_q) begin
                    if (!grant_found) begin
                        held_d[id_q] = 1'b0;
                    end else begin
                        owner_d[id_q]              = grant_tid;
                        waiters_d[id_q][grant_tid] = 1'b0;
                        ack_data_d                 = ACK_OK_CODE;
                        ack_dest_d                 = grant_tid;
                        state_d                    = StSendAck;
                    end
                end
            end
            StSendAck: begin
                if (outStream_TREADY) begin
                    state_d = StReadCmd;
                end
            end
            default: state_d = StReadCmd;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StReadCmd;
            cmd_q      <= '0;
            id_q       <= '0;
            tid_q      <= '0;
            held_q     <= '0;
            owner_q    <= '0;
            waiters_q  <= '0;
            ack_data_q <= '0;
            ack_dest_q <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            id_q       <= id_d;
            tid_q      <= tid_d;
            held_q     <= held_d;
            owner_q    <= owner_d;
            waiters_q  <= waiters_d;
            ack_data_q <= ack_data_d;
            ack_dest_q <= ack_dest_d;
        end
    end

    // Gated by rstn so the input side reads not-ready while reset is held.
    assign inStream_TREADY  = (state_q == StReadCmd) && rstn;
    assign outStream_TVALID = (state_q == StSendAck);
    assign outStream_TDATA  = ack_data_q;
    assign outStream_TDEST  = ack_dest_q;

endmodule

// File: tb/tb_lock_queue_arbiter.sv
// Self-checking bench for lock_queue_arbiter: directed scenarios plus random commands
// checked against a per-lock reference model.
module tb_lock_queue_arbiter;

    localparam int NumLocks = 4;
    localparam logic [7:0] Lock   = 8'h04;
    localparam logic [7:0] Unlock = 8'h05;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_tid = '0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_dest;

    int checks = 0;
    int errors = 0;

    bit        m_held[16];
    int        m_owner[16];
    bit [15:0] m_wait[16];

    lock_queue_arbiter #(.NUM_LOCKS(NumLocks)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .inStream_TDATA   (in_data),
        .inStream_TVALID  (in_valid),
        .inStream_TID     (in_tid),
        .inStream_TREADY  (in_ready),
        .outStream_TDATA  (out_data),
        .outStream_TVALID (out_valid),
        .outStream_TREADY (out_ready),
        .outStream_TDEST  (out_dest)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_held[i] = 1'b0;
            m_owner[i] = 0;
            m_wait[i] = '0;
        end
    endtask

    task automatic model_cmd(input logic [3:0] tid, input logic [7:0] cmd, input logic [7:0] id,
                             output logic ack, output logic [7:0] data, output logic [3:0] dest);
        int l;
        int nxt;
        l = int'(id) % NumLocks;
        ack = 1'b0;
        data = '0;
        dest = '0;
        if (cmd == Lock) begin
            if (!m_held[l]) begin
                m_held[l] = 1'b1;
                m_owner[l] = int'(tid);
                ack = 1'b1; data = 8'h01; dest = tid;
            end else if (m_owner[l] == int'(tid)) begin
                ack = 1'b1; data = 8'h00; dest = tid;
            end else begin
                m_wait[l][tid] = 1'b1;
            end
        end else if (cmd == Unlock && m_held[l] && m_owner[l] == int'(tid)) begin
            nxt = -1;
            for (int k = 1; k <= 16; k++) begin
                if (nxt < 0 && m_wait[l][(m_owner[l] + k) % 16]) nxt = (m_owner[l] + k) % 16;
            end
            if (nxt < 0) begin
                m_held[l] = 1'b0;
            end else begin
                m_owner[l] = nxt;
                m_wait[l][nxt] = 1'b0;
                ack = 1'b1; data = 8'h01; dest = 4'(nxt);
            end
        end
    endtask

    // Called #1 after a rising edge. stall < 0 leaves the ack pending with TREADY low.
    task automatic send_cmd(input logic [3:0] tid, input logic [7:0] cmd, input logic [7:0] id,
                            input int stall, output logic got, output logic [7:0] got_data,
                            output logic [3:0] got_dest);
        logic exp_ack;
        logic [7:0] exp_data;
        logic [3:0] exp_dest;
        int n;
        model_cmd(tid, cmd, id, exp_ack, exp_data, exp_dest);
        got = 1'b0; got_data = '0; got_dest = '0;
        out_ready = (stall == 0);
        in_data = {$urandom(), $urandom()};
        in_data[7:0] = cmd;
        in_data[15:8] = id;
        in_tid = tid;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout tready=%b want 1", in_ready);
            in_valid = 1'b0;
            out_ready = 1'b1;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL decode_cycle tvalid=%b tready=%b want 0/0", out_valid, in_ready);
        end
        @(posedge clk); #1;
        got = out_valid; got_data = out_data; got_dest = out_dest;
        checks++;
        if (got !== exp_ack) begin
            errors++;
            $display("FAIL ack_valid tid=%0d cmd=%h id=%0d got %b want %b",
                     tid, cmd, id, got, exp_ack);
        end
        if (exp_ack && got === 1'b1) begin
            checks++;
            if (got_data !== exp_data || got_dest !== exp_dest) begin
                errors++;
                $display("FAIL ack_payload data=%h dest=%0d want %h/%0d",
                         got_data, got_dest, exp_data, exp_dest);
            end
            if (stall < 0) return;
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                checks++;
                if (out_valid !== 1'b1 || out_data !== got_data || out_dest !== got_dest
                    || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ack_hold cyc=%0d v=%b d=%h t=%0d rdy=%b want 1/%h/%0d/0",
                             i, out_valid, out_data, out_dest, in_ready, got_data, got_dest);
                end
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL ack_done tvalid=%b tready=%b want 0/1", out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        logic g; logic [7:0] gd; logic [3:0] gt;
        model_reset();
        #12;
        checks++;
        if ({in_ready, out_valid, out_data, out_dest} !== 14'h0) begin
            errors++;
            $display("FAIL reset_outputs rdy=%b v=%b d=%h t=%h want all 0",
                     in_ready, out_valid, out_data, out_dest);
        end
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release tready=%b want 1", in_ready);
        end
        // Lock 0 free after reset: any LOCK is granted.
        send_cmd(4'd0, Lock, 8'd0, 0, g, gd, gt);
        send_cmd(4'd0, Unlock, 8'd0, 0, g, gd, gt);
    endtask

    task automatic test_grant_free();
        logic g; logic [7:0] gd; logic [3:0] gt;
        send_cmd(4'd3, Lock, 8'd0, 0, g, gd, gt);
        checks++;
        if ({g, gd, gt} !== {1'b1, 8'h01, 4'd3}) begin
            errors++;
            $display("FAIL grant_free got %b/%h/%0d want 1/01/3", g, gd, gt);
        end
        send_cmd(4'd3, Lock, 8'd0, 0, g, gd, gt);
        checks++;
        if ({g, gd, gt} !== {1'b1, 8'h00, 4'd3}) begin
            errors++;
            $display("FAIL grant_owner got %b/%h/%0d want 1/00/3", g, gd, gt);
        end
    endtask

    task automatic test_round_robin();
        logic g; logic [7:0] gd; logic [3:0] gt;
        send_cmd(4'd7, Lock, 8'd0, 0, g, gd, gt);
        send_cmd(4'd1, Lock, 8'd0, 0, g, gd, gt);
        send_cmd(4'd3, Unlock, 8'd0, 0, g, gd, gt);
        checks++;
        if ({g, gd, gt} !== {1'b1, 8'h01, 4'd7}) begin
            errors++;
            $display("FAIL rr_first got %b/%h/%0d want 1/01/7", g, gd, gt);
        end
        send_cmd(4'd7, Unlock, 8'd0, 0, g, gd, gt);
        checks++;
        if ({g, gd, gt} !== {1'b1, 8'h01, 4'd1}) begin
            errors++;
            $display("FAIL rr_wrap got %b/%h/%0d want 1/01/1", g, gd, gt);
        end
        send_cmd(4'd1, Unlock, 8'd0, 0, g, gd, gt);
        send_cmd(4'd11, Lock, 8'd0, 0, g, gd, gt);
        checks++;
        if ({g, gd, gt} !== {1'b1, 8'h01, 4'd11}) begin
            errors++;
            $display("FAIL rr_freed got %b/%h/%0d want 1/01/11", g, gd, gt);
        end
        send_cmd(4'd11, Unlock, 8'd0, 0, g, gd, gt);
    endtask

    task automatic test_self_lock();
        logic g; logic [7:0] gd; logic [3:0] gt;
        send_cmd(4'd5, Lock, 8'd2, 0, g, gd, gt);
        send_cmd(4'd5, Lock, 8'd2, 0, g, gd, gt);
        checks++;
        if ({g, gd, gt} !== {1'b1, 8'h00, 4'd5}) begin
            errors++;
            $display("FAIL self_reject got %b/%h/%0d want 1/00/5", g, gd, gt);
        end
        send_cmd(4'd9, Unlock, 8'd2, 0, g, gd, gt);
        send_cmd(4'd9, Lock, 8'd2, 0, g, gd, gt);
        send_cmd(4'd5, Unlock, 8'd2, 0, g, gd, gt);
        checks++;
        if ({g, gd, gt} !== {1'b1, 8'h01, 4'd9}) begin
            errors++;
            $display("FAIL foreign_unlock got %b/%h/%0d want 1/01/9", g, gd, gt);
        end
        send_cmd(4'd9, Unlock, 8'd2, 0, g, gd, gt);
    endtask

    task automatic test_backpressure();
        logic g; logic [7:0] gd; logic [3:0] gt;
        send_cmd(4'd8, Lock, 8'd3, 10, g, gd, gt);
        checks++;
        if ({g, gd, gt} !== {1'b1, 8'h01, 4'd8}) begin
            errors++;
            $display("FAIL backpressure got %b/%h/%0d want 1/01/8", g, gd, gt);
        end
        send_cmd(4'd8, Unlock, 8'd3, 0, g, gd, gt);
    endtask

    task automatic test_independence();
        logic g; logic [7:0] gd; logic [3:0] gt;
        send_cmd(4'd2, Lock, 8'd1, 0, g, gd, gt);
        send_cmd(4'd4, Lock, 8'd3, 0, g, gd, gt);
        send_cmd(4'd4, Unlock, 8'd1, 0, g, gd, gt);
        send_cmd(4'd2, Lock, 8'd1, 0, g, gd, gt);
        checks++;
        if ({g, gd, gt} !== {1'b1, 8'h00, 4'd2}) begin
            errors++;
            $display("FAIL indep_lock1 got %b/%h/%0d want 1/00/2", g, gd, gt);
        end
        send_cmd(4'd4, Lock, 8'd3, 0, g, gd, gt);
        checks++;
        if ({g, gd, gt} !== {1'b1, 8'h00, 4'd4}) begin
            errors++;
            $display("FAIL indep_lock3 got %b/%h/%0d want 1/00/4", g, gd, gt);
        end
        send_cmd(4'd2, Unlock, 8'd1, 0, g, gd, gt);
        send_cmd(4'd4, Unlock, 8'd3, 0, g, gd, gt);
    endtask

    task automatic test_reset_mid_ack();
        logic g; logic [7:0] gd; logic [3:0] gt;
        send_cmd(4'd3, Lock, 8'd0, 0, g, gd, gt);
        send_cmd(4'd7, Lock, 8'd0, 0, g, gd, gt);
        send_cmd(4'd1, Lock, 8'd0, 0, g, gd, gt);
        send_cmd(4'd3, Unlock, 8'd0, -1, g, gd, gt);
        rstn = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({in_ready, out_valid, out_data, out_dest} !== 14'h0) begin
            errors++;
            $display("FAIL reset_mid_ack rdy=%b v=%b d=%h t=%h want all 0",
                     in_ready, out_valid, out_data, out_dest);
        end
        out_ready = 1'b1;
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_ack_release rdy=%b v=%b want 1/0", in_ready, out_valid);
        end
        send_cmd(4'd6, Lock, 8'd0, 0, g, gd, gt);
        checks++;
        if ({g, gd, gt} !== {1'b1, 8'h01, 4'd6}) begin
            errors++;
            $display("FAIL post_reset_grant got %b/%h/%0d want 1/01/6", g, gd, gt);
        end
        send_cmd(4'd6, Unlock, 8'd0, 0, g, gd, gt);
    endtask

    task automatic test_random();
        logic g; logic [7:0] gd; logic [3:0] gt;
        logic [7:0] cmd;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 4))
                0, 1:    cmd = Lock;
                2, 3:    cmd = Unlock;
                default: cmd = 8'($urandom_range(6, 255));
            endcase
            send_cmd(4'($urandom_range(0, 5) * 3), cmd, 8'($urandom()),
                     int'($urandom_range(0, 3)), g, gd, gt);
        end
    endtask

    initial begin
        test_reset();
        test_grant_free();
        test_round_robin();
        test_self_lock();
        test_backpressure();
        test_independence();
        test_reset_mid_ack();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lock_queue_arbiter.md
LOCK_QUEUE_ARBITER -- requirements
Module: lock_queue_arbiter

Interface
REQ-001 SHALL have parameter NUM_LOCKS, default 4, number of independent locks (power of 2, 1..16).
REQ-002 SHALL have parameter CMD_LOCK_CODE, default 8'h04, lock request command.
REQ-003 SHALL have parameter CMD_UNLOCK_CODE, default 8'h05, unlock command.
REQ-004 SHALL have parameter ACK_OK_CODE, default 8'h01, grant ack; ACK_REJECT_CODE, default 8'h00, reject ack.
REQ-005 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-006 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port inStream_TDATA  in  64  command; [7:0] cmd code, [15:8] lock id (low log2(NUM_LOCKS) bits used).
REQ-008 SHALL have port inStream_TVALID  in  1; inStream_TID  in  4  requesting accelerator id; inStream_TREADY  out  1.
REQ-009 SHALL have port outStream_TDATA  out  8  ack code; outStream_TVALID  out  1; outStream_TREADY  in  1; outStream_TDEST  out  4  target accelerator.

Function
REQ-010 SHALL keep per lock: held bit, 4-bit owner, 16-bit waiter mask.
REQ-011 SHALL use FSM states READ_CMD, DECODE, SEND_ACK.
REQ-012 SHALL assert inStream_TREADY only in READ_CMD; handshake TVALID&TREADY captures TID, cmd, lock id and moves to DECODE.
REQ-013 DECODE, LOCK, lock free: set held, owner=TID, ack ACK_OK to TID, go SEND_ACK.
REQ-014 DECODE, LOCK, held, TID==owner: no state change, ack ACK_REJECT to TID, go SEND_ACK.
REQ-015 DECODE, LOCK, held by other: set waiter bit TID (idempotent), no ack, go READ_CMD.
REQ-016 DECODE, UNLOCK, TID==owner, mask empty: clear held, no ack, go READ_CMD.
REQ-017 DECODE, UNLOCK, TID==owner, mask non-empty: select first set bit scanning owner+1, owner+2, ... mod 16; owner=selected, clear its waiter bit, held stays 1, ack ACK_OK to selected, go SEND_ACK.
REQ-018 DECODE, UNLOCK by non-owner or on free lock: no state change, no ack, go READ_CMD.
REQ-019 DECODE, any other cmd code: ignored, go READ_CMD.
REQ-020 SEND_ACK: outStream_TVALID=1, TDATA/TDEST held stable until TREADY; on TREADY return to READ_CMD.
REQ-021 Latency: command accepted cycle T -> outStream_TVALID high at T+2 earliest; one command in flight at a time.
REQ-022 outStream_TVALID SHALL be 0 in every state but SEND_ACK.
REQ-023 Waiter-bit update, owner change and ack data SHALL be registered in the same DECODE edge; no lock table change in READ_CMD or SEND_ACK.
REQ-024 Locks SHALL be fully independent; a command never alters another lock id's entry.

Reset
REQ-025 rstn low SHALL asynchronously force state READ_CMD, all held=0, all waiter masks=0, owners=0.
REQ-026 During reset: inStream_TREADY=0, outStream_TVALID=0, outStream_TDATA=0, outStream_TDEST=0.
REQ-027 Reset mid-SEND_ACK SHALL drop the pending ack; first post-reset cycle SHALL be READ_CMD with TREADY=1.

Verification
REQ-028 TID 3 LOCK id 0 on free lock -> ack 8'h01 to TDEST 3 at T+2; lock 0 held, owner 3.
REQ-029 TID 3 holds lock 0; TID 7, then TID 1 LOCK id 0 -> no acks; TID 3 UNLOCK -> ack 8'h01 to TDEST 7 (round-robin from 4); TID 7 UNLOCK -> ack 8'h01 to TDEST 1; TID 1 UNLOCK -> lock free, no ack.
REQ-030 TID 5 holds lock 2; TID 5 LOCK id 2 -> ack 8'h00 to TDEST 5, owner unchanged; TID 9 UNLOCK id 2 -> ignored, TID 5 still owner.
REQ-031 Backpressure: outStream_TREADY=0 for 10 cycles during ack -> TVALID/TDATA/TDEST stable, inStream_TREADY=0 throughout; ack completes on first TREADY cycle.
REQ-032 TID 2 holds lock 1, TID 4 holds lock 3; TID 4 UNLOCK id 1 -> no change on either lock.
REQ-033 rstn low during SEND_ACK with waiters queued -> TVALID drops immediately; after release, TID 6 LOCK on same id -> ack 8'h01 to TDEST 6.
